// File: rtl/audio_buf_pkg.sv
// Shared definitions for the audio record/playback buffer.
// Provides the iMODE encodings and the controller state enum.
package audio_buf_pkg;

  localparam logic [1:0] MODE_IDLE = 2'd0;
  localparam logic [1:0] MODE_REC  = 2'd1;
  localparam logic [1:0] MODE_PLAY = 2'd2;
  localparam logic [1:0] MODE_LOOP = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REC  = 2'd1,
    S_PLAY = 2'd2,
    S_LOOP = 2'd3
  } state_e;

endpackage

// File: rtl/audio_frame_ram.sv
// Single-port synchronous frame store, read-first, one cycle read latency.
// Ports:
//   clk   - clock
//   we    - write enable for wdata at addr
//   addr  - frame address (read and write share it)
//   wdata - frame to write
//   rdata - frame at addr as it was before this edge's write
module audio_frame_ram #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned DEPTH  = 24000,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Plain registered read plus write on one port so the tools map it to block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/audio_record_buffer.sv
// Multi-channel record/playback buffer between the sample strobe logic and the
// audio converter. Records frames into on-chip RAM and replays them once or looped.
// Ports:
//   iCLK, rst        - clock, synchronous active-high reset
//   iSAMPLE_VALID    - one-cycle frame strobe
//   iSAMPLE_IN       - input frame (ch0 in LSBs)
//   iMODE            - operation selected on iSTART
//   iSTART, iSTOP    - operation control pulses
//   oSAMPLE_OUT      - output frame (playback data or monitored input)
//   oSAMPLE_VALID    - pulse marking a new oSAMPLE_OUT
//   oBUSY            - recording or playing
//   oFULL            - last recording filled the whole store
//   oLENGTH          - stored frame count
//   oADDR            - current frame pointer
module audio_record_buffer
  import audio_buf_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DEPTH    = 24000,
  parameter int unsigned ADDR_W   = $clog2(DEPTH)
) (
  input  logic                         iCLK,
  input  logic                         rst,
  input  logic                         iSAMPLE_VALID,
  input  logic [CHANNELS*SAMPLE_W-1:0] iSAMPLE_IN,
  input  logic [1:0]                   iMODE,
  input  logic                         iSTART,
  input  logic                         iSTOP,
  output logic [CHANNELS*SAMPLE_W-1:0] oSAMPLE_OUT,
  output logic                         oSAMPLE_VALID,
  output logic                         oBUSY,
  output logic                         oFULL,
  output logic [ADDR_W:0]              oLENGTH,
  output logic [ADDR_W-1:0]            oADDR
);

  localparam int unsigned FRAME_W = CHANNELS * SAMPLE_W;
  localparam int unsigned LEN_W   = ADDR_W + 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                full_q, full_d;
  logic                ram_we;
  logic                vld_d, vld_q;
  logic                src_ram_d, src_ram_q;
  logic [FRAME_W-1:0]  in_q, hold_q, ram_rdata, frame_now;
  logic [LEN_W-1:0]    ptr_ext;
  logic                last_rec, last_play;

  audio_frame_ram #(
    .WIDTH  (FRAME_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (iCLK),
    .we    (ram_we),
    .addr  (ptr_q),
    .wdata (iSAMPLE_IN),
    .rdata (ram_rdata)
  );

  // Comparisons done one bit wider than the pointer so DEPTH and oLENGTH fit.
  assign ptr_ext   = {1'b0, ptr_q};
  assign last_rec  = (ptr_q == ADDR_W'(DEPTH - 1));
  assign last_play = ((ptr_ext + LEN_W'(1)) == len_q);

  // Controller state, pointer, length and full flag.
  always_ff @(posedge iCLK) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      full_q  <= full_d;
    end
  end

  // Next-state logic; every exit to S_IDLE parks the pointer at 0.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    len_d     = len_q;
    full_d    = full_q;
    ram_we    = 1'b0;
    vld_d     = 1'b0;
    src_ram_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        vld_d = iSAMPLE_VALID;
        if (iSTART && !iSTOP) begin
          case (iMODE)
            MODE_REC: begin
              state_d = S_REC;
              ptr_d   = '0;
              full_d  = 1'b0;
            end
            MODE_PLAY: begin
              state_d = S_PLAY;
              ptr_d   = '0;
            end
            MODE_LOOP: begin
              state_d = S_LOOP;
              ptr_d   = '0;
            end
            default: ;
          endcase
        end
      end

      S_REC: begin
        vld_d = iSAMPLE_VALID;
        if (iSAMPLE_VALID) begin
          ram_we = 1'b1;
          if (last_rec) begin
            len_d   = LEN_W'(DEPTH);
            full_d  = 1'b1;
            state_d = S_IDLE;
            ptr_d   = '0;
          end else if (iSTOP) begin
            len_d   = ptr_ext + LEN_W'(1);
            state_d = S_IDLE;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end else if (iSTOP) begin
          len_d   = ptr_ext;
          state_d = S_IDLE;
          ptr_d   = '0;
        end
      end

      S_PLAY, S_LOOP: begin
        if (len_q == '0) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end else if (iSAMPLE_VALID) begin
          vld_d     = 1'b1;
          src_ram_d = 1'b1;
          if (iSTOP || (last_play && (state_q == S_PLAY))) begin
            state_d = S_IDLE;
            ptr_d   = '0;
          end else if (last_play) begin
            ptr_d = '0;
          end else begin
            ptr_d = ptr_q + ADDR_W'(1);
          end
        end else if (iSTOP) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Output path: the frame is valid the cycle after its strobe, taken either
  // from the RAM read port or from the captured input, then held.
  always_ff @(posedge iCLK) begin
    if (rst) begin
      vld_q     <= 1'b0;
      src_ram_q <= 1'b0;
      in_q      <= '0;
      hold_q    <= '0;
    end else begin
      vld_q     <= vld_d;
      src_ram_q <= src_ram_d;
      if (iSAMPLE_VALID) begin
        in_q <= iSAMPLE_IN;
      end
      if (vld_q) begin
        hold_q <= frame_now;
      end
    end
  end

  assign frame_now     = src_ram_q ? ram_rdata : in_q;
  assign oSAMPLE_OUT   = vld_q ? frame_now : hold_q;
  assign oSAMPLE_VALID = vld_q;
  assign oBUSY         = (state_q != S_IDLE);
  assign oFULL         = full_q;
  assign oLENGTH       = len_q;
  assign oADDR         = ptr_q;

endmodule

// File: tb/tb_audio_record_buffer.sv
// Self-checking bench for audio_record_buffer (DEPTH=8, 2 x 16-bit frames).
module tb_audio_record_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned FW    = 32;
  localparam int unsigned AW    = 3;
  localparam int unsigned LW    = 4;

  typedef logic [FW-1:0] frame_t;

  typedef struct {
    logic       v;
    frame_t     d;
    logic       st;
    logic       sp;
    logic [1:0] md;
    logic       e_vld;
    frame_t     e_out;
    logic       e_busy;
    int         e_len;
    logic       e_full;
  } vec_t;

  logic          iCLK = 1'b0;
  logic          rst = 1'b1;
  logic          iSAMPLE_VALID = 1'b0;
  frame_t        iSAMPLE_IN = '0;
  logic [1:0]    iMODE = 2'd0;
  logic          iSTART = 1'b0;
  logic          iSTOP = 1'b0;
  frame_t        oSAMPLE_OUT;
  logic          oSAMPLE_VALID;
  logic          oBUSY;
  logic          oFULL;
  logic [LW-1:0] oLENGTH;
  logic [AW-1:0] oADDR;

  int errors = 0;
  int checks = 0;

  audio_record_buffer #(
    .SAMPLE_W (16),
    .CHANNELS (2),
    .DEPTH    (DEPTH)
  ) dut (
    .iCLK          (iCLK),
    .rst           (rst),
    .iSAMPLE_VALID (iSAMPLE_VALID),
    .iSAMPLE_IN    (iSAMPLE_IN),
    .iMODE         (iMODE),
    .iSTART        (iSTART),
    .iSTOP         (iSTOP),
    .oSAMPLE_OUT   (oSAMPLE_OUT),
    .oSAMPLE_VALID (oSAMPLE_VALID),
    .oBUSY         (oBUSY),
    .oFULL         (oFULL),
    .oLENGTH       (oLENGTH),
    .oADDR         (oADDR)
  );

  always #5 iCLK = ~iCLK;

  // Reference model: op 0 idle, 1 recording, 2 play once, 3 loop.
  // cnt counts frames recorded or frames played since the start.
  int     m_op = 0;
  int     m_cnt = 0;
  int     m_len = 0;
  bit     m_full = 1'b0;
  bit     m_vld = 1'b0;
  frame_t m_out = '0;
  frame_t m_mem [DEPTH];

  function automatic int m_addr();
    if (m_op == 0) return 0;
    if (m_op == 1) return m_cnt;
    if (m_len == 0) return 0;
    return m_cnt % m_len;
  endfunction

  task automatic model_step(input logic v, input frame_t d, input logic st,
                            input logic sp, input logic [1:0] md, input logic r);
    m_vld = 1'b0;
    if (r) begin
      m_op = 0; m_cnt = 0; m_len = 0; m_full = 1'b0; m_out = '0;
      return;
    end
    case (m_op)
      0: begin
        if (v) begin m_vld = 1'b1; m_out = d; end
        if (st && !sp && md != 2'd0) begin
          m_op = int'(md);
          m_cnt = 0;
          if (md == 2'd1) m_full = 1'b0;
        end
      end
      1: begin
        if (v) begin
          m_vld = 1'b1; m_out = d;
          m_mem[m_cnt] = d;
          m_cnt++;
          if (m_cnt == DEPTH) begin m_len = DEPTH; m_full = 1'b1; m_op = 0; end
          else if (sp) begin m_len = m_cnt; m_op = 0; end
        end else if (sp) begin
          m_len = m_cnt; m_op = 0;
        end
      end
      default: begin
        if (m_len == 0) m_op = 0;
        else if (v) begin
          m_vld = 1'b1;
          m_out = m_mem[m_cnt % m_len];
          m_cnt++;
          if (sp || (m_op == 2 && m_cnt == m_len)) m_op = 0;
        end else if (sp) m_op = 0;
      end
    endcase
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, take the edge, then compare against the model.
  task automatic tick(input logic v, input frame_t d, input logic st,
                      input logic sp, input logic [1:0] md, input logic r);
    rst = r; iSAMPLE_VALID = v; iSAMPLE_IN = d; iSTART = st; iSTOP = sp; iMODE = md;
    @(posedge iCLK);
    #1;
    rst = 1'b0; iSAMPLE_VALID = 1'b0; iSTART = 1'b0; iSTOP = 1'b0;
    model_step(v, d, st, sp, md, r);
    check("model_valid", 64'(oSAMPLE_VALID), 64'(m_vld));
    check("model_out",   64'(oSAMPLE_OUT),   64'(m_out));
    check("model_busy",  64'(oBUSY),         64'(m_op != 0));
    check("model_full",  64'(oFULL),         64'(m_full));
    check("model_len",   64'(oLENGTH),       64'(m_len));
    check("model_addr",  64'(oADDR),         64'(m_addr()));
  endtask

  task automatic idle();
    tick(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic start(input logic [1:0] md);
    tick(1'b0, '0, 1'b1, 1'b0, md, 1'b0);
  endtask

  task automatic strobe(input frame_t d, input logic sp);
    tick(1'b1, d, 1'b0, sp, 2'd0, 1'b0);
  endtask

  vec_t   tbl[$];
  frame_t lf[3];

  function automatic vec_t mk(input logic v, input frame_t d, input logic st, input logic sp,
                              input logic [1:0] md, input logic ev, input frame_t eo,
                              input logic eb, input int el, input logic ef);
    vec_t x;
    x.v = v; x.d = d; x.st = st; x.sp = sp; x.md = md;
    x.e_vld = ev; x.e_out = eo; x.e_busy = eb; x.e_len = el; x.e_full = ef;
    return x;
  endfunction

  initial begin
    frame_t f;
    int gap;
    logic v, st, sp, r;

    // Reset state
    tick(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b1);
    check("reset_out",  64'(oSAMPLE_OUT), 64'd0);
    check("reset_busy", 64'(oBUSY), 64'd0);
    check("reset_len",  64'(oLENGTH), 64'd0);

    // Record 5 frames, stop, then play them once.
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b0, 2'd1, 1'b0, '0, 1'b1, 0, 1'b0));
    for (int k = 1; k <= 5; k++) begin
      f = 32'h0001_0001 * 32'(k);
      tbl.push_back(mk(1'b1, f, 1'b0, 1'b0, 2'd0, 1'b1, f, 1'b1, 0, 1'b0));
      tbl.push_back(mk(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b0, f, 1'b1, 0, 1'b0));
      tbl.push_back(mk(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b0, f, 1'b1, 0, 1'b0));
    end
    tbl.push_back(mk(1'b0, '0, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0005_0005, 1'b0, 5, 1'b0));
    tbl.push_back(mk(1'b0, '0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0005_0005, 1'b1, 5, 1'b0));
    for (int k = 1; k <= 5; k++) begin
      f = 32'h0001_0001 * 32'(k);
      tbl.push_back(mk(1'b1, 32'hDEAD_0000 + 32'(k), 1'b0, 1'b0, 2'd0, 1'b1, f, k < 5, 5, 1'b0));
      tbl.push_back(mk(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b0, f, k < 5, 5, 1'b0));
      tbl.push_back(mk(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b0, f, k < 5, 5, 1'b0));
    end
    foreach (tbl[i]) begin
      tick(tbl[i].v, tbl[i].d, tbl[i].st, tbl[i].sp, tbl[i].md, 1'b0);
      check("vec_valid", 64'(oSAMPLE_VALID), 64'(tbl[i].e_vld));
      check("vec_out",   64'(oSAMPLE_OUT),   64'(tbl[i].e_out));
      check("vec_busy",  64'(oBUSY),         64'(tbl[i].e_busy));
      check("vec_len",   64'(oLENGTH),       64'(tbl[i].e_len));
      check("vec_full",  64'(oFULL),         64'(tbl[i].e_full));
    end

    // Fill to DEPTH with 10 strobes: 8 stored, the rest only echoed.
    start(2'd1);
    for (int i = 0; i < 10; i++) begin
      f = 32'h0100_0000 + 32'(i);
      strobe(f, 1'b0);
      if (i == 7) begin
        check("fill_full", 64'(oFULL), 64'd1);
        check("fill_len",  64'(oLENGTH), 64'd8);
        check("fill_busy", 64'(oBUSY), 64'd0);
      end
      if (i == 8) begin
        check("fill_echo_vld", 64'(oSAMPLE_VALID), 64'd1);
        check("fill_echo_out", 64'(oSAMPLE_OUT), 64'(f));
        check("fill_len_keep", 64'(oLENGTH), 64'd8);
      end
      idle(); idle();
    end

    // Loop over 3 frames for 7 strobes, stop on the 7th.
    lf[0] = 32'hAAAA_0001; lf[1] = 32'hBBBB_0002; lf[2] = 32'hCCCC_0003;
    start(2'd1);
    for (int i = 0; i < 3; i++) begin strobe(lf[i], 1'b0); idle(); idle(); end
    tick(1'b0, '0, 1'b0, 1'b1, 2'd0, 1'b0);
    check("loop_len", 64'(oLENGTH), 64'd3);
    check("loop_full_clr", 64'(oFULL), 64'd0);
    start(2'd3);
    for (int j = 0; j < 7; j++) begin
      strobe(32'h5555_0000 + 32'(j), j == 6);
      check("loop_seq", 64'(oSAMPLE_OUT), 64'(lf[j % 3]));
      idle(); idle();
    end
    check("loop_end_busy", 64'(oBUSY), 64'd0);

    // iSTART while recording is ignored.
    start(2'd1);
    strobe(32'h1111_1111, 1'b0);
    idle();
    start(2'd2);
    check("rec_start_ign", 64'(oBUSY), 64'd1);
    strobe(32'h2222_2222, 1'b0);
    check("rec_addr", 64'(oADDR), 64'd2);
    idle(); idle();
    tick(1'b0, '0, 1'b0, 1'b1, 2'd0, 1'b0);
    check("rec_len2", 64'(oLENGTH), 64'd2);

    // iSTART and iSTOP together: stop wins.
    tick(1'b0, '0, 1'b1, 1'b1, 2'd1, 1'b0);
    check("start_stop_idle", 64'(oBUSY), 64'd0);
    tick(1'b0, '0, 1'b0, 1'b1, 2'd0, 1'b0);

    // Reset mid-play, then play with nothing stored.
    start(2'd2);
    strobe(32'h7777_7777, 1'b0);
    tick(1'b0, '0, 1'b0, 1'b0, 2'd0, 1'b1);
    check("rst_out",  64'(oSAMPLE_OUT), 64'd0);
    check("rst_vld",  64'(oSAMPLE_VALID), 64'd0);
    check("rst_busy", 64'(oBUSY), 64'd0);
    check("rst_len",  64'(oLENGTH), 64'd0);
    check("rst_addr", 64'(oADDR), 64'd0);
    start(2'd2);
    check("len0_busy", 64'(oBUSY), 64'd1);
    strobe(32'h8888_8888, 1'b0);
    check("len0_novld", 64'(oSAMPLE_VALID), 64'd0);
    check("len0_idle", 64'(oBUSY), 64'd0);
    idle(); idle();

    // Randomized traffic against the model.
    gap = 3;
    for (int n = 0; n < 1500; n++) begin
      v  = (gap >= 3) && ($urandom_range(0, 1) == 1);
      st = ($urandom_range(0, 7) == 0);
      sp = ($urandom_range(0, 11) == 0);
      r  = ($urandom_range(0, 299) == 0);
      tick(v, frame_t'($urandom), st, sp, 2'($urandom_range(0, 3)), r);
      gap = v ? 1 : gap + 1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
